// File: rtl/axis_skid_pkg.sv
// rtl/axis_skid_pkg.sv - shared types for the AXI4-Stream register slice
package axis_skid_pkg;

  typedef enum {SKID_BYPASS, SKID_FWD, SKID_FULL} skid_mode_e;

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} skid_state_e;

  localparam int OCC_W = 2;

endpackage

// File: rtl/axis_skid_reg.sv
// rtl/axis_skid_reg.sv - enable-loaded payload register with async reset and sync clear
module axis_skid_reg #(
  parameter int W          = 9,
  parameter bit RESET_DATA = 1'b1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (RESET_DATA) begin : g_rst
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)    q <= '0;
        else if (clr) q <= '0;
        else if (en)  q <= d;
      end
    end else begin : g_nrst
      // Payload is qualified by valid, so stale contents are harmless here.
      always_ff @(posedge clk) begin
        if (en) q <= d;
      end
    end
  endgenerate

endmodule

// File: rtl/axis_skid_buffer_p.sv
// rtl/axis_skid_buffer_p.sv - AXI4-Stream register slice with selectable full/forward/bypass mode
module axis_skid_buffer_p
  import axis_skid_pkg::*;
#(
  parameter int         DATA_SIZE  = 8,
  parameter skid_mode_e MODE       = SKID_FULL,
  parameter bit         RESET_DATA = 1'b1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  input  logic [DATA_SIZE-1:0] s_data,
  input  logic                 s_last,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [DATA_SIZE-1:0] m_data,
  output logic                 m_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OCC_W-1:0]     occupancy
);

  localparam int W = DATA_SIZE + 1;

  generate
    if (MODE == SKID_FULL) begin : g_full
      skid_state_e    state;
      logic           rdy_q, vld_q;
      logic           in_hs, out_hs, main_en, skid_en;
      logic [W-1:0]   main_d, main_q, skid_q;

      // flush voids both handshakes of its cycle
      assign s_ready = rdy_q && !flush;
      assign in_hs   = s_valid && s_ready;
      assign out_hs  = vld_q && m_ready && !flush;

      always_comb begin
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = {s_last, s_data};
        case (state)
          EMPTY: main_en = in_hs;
          BUSY: begin
            main_en = in_hs && out_hs;
            skid_en = in_hs && !out_hs;
          end
          FULL: begin
            main_en = out_hs;
            main_d  = skid_q;
          end
          default: ;
        endcase
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          state <= EMPTY;
          rdy_q <= 1'b0;
          vld_q <= 1'b0;
        end else if (flush) begin
          state <= EMPTY;
          rdy_q <= 1'b1;
          vld_q <= 1'b0;
        end else begin
          case (state)
            EMPTY: begin
              rdy_q <= 1'b1;
              if (in_hs) begin
                state <= BUSY;
                vld_q <= 1'b1;
              end
            end
            BUSY: begin
              if (in_hs && !out_hs) begin
                state <= FULL;
                rdy_q <= 1'b0;
              end else if (out_hs && !in_hs) begin
                state <= EMPTY;
                vld_q <= 1'b0;
              end
            end
            FULL: begin
              if (out_hs) begin
                state <= BUSY;
                rdy_q <= 1'b1;
              end
            end
            default: begin
              state <= EMPTY;
              rdy_q <= 1'b1;
              vld_q <= 1'b0;
            end
          endcase
        end
      end

      axis_skid_reg #(.W(W), .RESET_DATA(RESET_DATA)) u_main (
        .clk(clk), .rstn(rstn), .clr(flush), .en(main_en), .d(main_d), .q(main_q)
      );
      axis_skid_reg #(.W(W), .RESET_DATA(RESET_DATA)) u_skid (
        .clk(clk), .rstn(rstn), .clr(flush), .en(skid_en), .d({s_last, s_data}), .q(skid_q)
      );

      assign m_valid   = vld_q;
      assign m_data    = main_q[DATA_SIZE-1:0];
      assign m_last    = main_q[DATA_SIZE];
      assign occupancy = OCC_W'(state);

    end else if (MODE == SKID_FWD) begin : g_fwd
      logic         vld_q, in_hs;
      logic [W-1:0] main_q;

      assign s_ready = (m_ready || !vld_q) && !flush;
      assign in_hs   = s_valid && s_ready;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        vld_q <= 1'b0;
        else if (flush)   vld_q <= 1'b0;
        else if (in_hs)   vld_q <= 1'b1;
        else if (m_ready) vld_q <= 1'b0;
      end

      axis_skid_reg #(.W(W), .RESET_DATA(RESET_DATA)) u_main (
        .clk(clk), .rstn(rstn), .clr(flush), .en(in_hs), .d({s_last, s_data}), .q(main_q)
      );

      assign m_valid   = vld_q;
      assign m_data    = main_q[DATA_SIZE-1:0];
      assign m_last    = main_q[DATA_SIZE];
      assign occupancy = {1'b0, vld_q};

    end else begin : g_bypass
      assign m_data    = s_data;
      assign m_last    = s_last;
      assign m_valid   = s_valid;
      assign s_ready   = m_ready;
      assign occupancy = '0;
    end
  endgenerate

endmodule
